// File: rtl/bht_table_pkg.sv
// Shared constants and types for the branch history table: default geometry,
// 2-bit counter encodings and the initialisation FSM states.
package bht_table_pkg;

    localparam int BHT_IDX_W = 10;
    localparam int BHT_TGT_W = 32;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } token_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } bht_state_t;

endpackage

// File: rtl/bht_table_if.sv
// Fetch-lookup and memory-stage update signals of the branch history table.
// The pipeline side is the master, the table is the slave.
interface bht_table_if #(
    parameter int IDX_W = bht_table_pkg::BHT_IDX_W,
    parameter int TGT_W = bht_table_pkg::BHT_TGT_W
);
    logic [IDX_W-1:0] rd_addr;
    logic [1:0]       rd_token;
    logic [TGT_W-1:0] rd_target;
    logic             pred_taken;
    logic             bht_we;
    logic [IDX_W-1:0] bht_write_addr;
    logic [TGT_W+1:0] bht_din;
    logic             busy;

    modport master (
        output rd_addr, bht_we, bht_write_addr, bht_din,
        input  rd_token, rd_target, pred_taken, busy
    );

    modport slave (
        input  rd_addr, bht_we, bht_write_addr, bht_din,
        output rd_token, rd_target, pred_taken, busy
    );
endinterface

// File: rtl/bht_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Read returns the old word on a same-address collision; callers bypass.
module bht_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 34
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/bht_table.sv
// Branch history table: {token, target} per entry, swept to a known value after
// reset, then read every cycle by fetch and written by the memory stage.
module bht_table
    import bht_table_pkg::*;
#(
    parameter int         IDX_W      = BHT_IDX_W,
    parameter int         TGT_W      = BHT_TGT_W,
    parameter logic [1:0] INIT_TOKEN = WEAK_NT
) (
    input  logic      clk,
    input  logic      rst,
    bht_table_if.slave bus
);
    localparam int             ENT_W    = 2 + TGT_W;
    localparam logic [IDX_W:0] LAST_IDX = {1'b0, {IDX_W{1'b1}}};
    localparam logic [IDX_W:0] IDX_ONE  = {{IDX_W{1'b0}}, 1'b1};

    bht_state_t       state_reg, state_next;
    logic [IDX_W:0]   init_idx_reg, init_idx_next;

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [ENT_W-1:0] ram_wdata;
    logic [ENT_W-1:0] ram_rdata;

    logic             byp_hit_reg;
    logic [ENT_W-1:0] byp_data_reg;
    logic [ENT_W-1:0] entry;
    logic [1:0]       token;
    logic             busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= ST_INIT;
            init_idx_reg <= '0;
            byp_hit_reg  <= 1'b0;
            byp_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            init_idx_reg <= init_idx_next;
            // Write-first behaviour: remember any write that lands on the word being read
            byp_hit_reg  <= ram_we && (ram_waddr == bus.rd_addr);
            byp_data_reg <= ram_wdata;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_idx_next = init_idx_reg;
        ram_we        = 1'b0;
        ram_waddr     = bus.bht_write_addr;
        ram_wdata     = bus.bht_din;
        case (state_reg)
            ST_INIT: begin
                // The sweep owns the write port; pipeline updates are dropped
                ram_we        = rst;
                ram_waddr     = init_idx_reg[IDX_W-1:0];
                ram_wdata     = {INIT_TOKEN, {TGT_W{1'b0}}};
                init_idx_next = init_idx_reg + IDX_ONE;
                if (init_idx_reg == LAST_IDX) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                ram_we = bus.bht_we && rst;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    bht_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (ENT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (bus.rd_addr),
        .rdata (ram_rdata)
    );

    assign busy  = (state_reg == ST_INIT);
    assign entry = byp_hit_reg ? byp_data_reg : ram_rdata;
    assign token = busy ? 2'b00 : entry[ENT_W-1 -: 2];

    assign bus.busy       = busy;
    assign bus.rd_token   = token;
    assign bus.rd_target  = busy ? '0 : entry[TGT_W-1:0];
    assign bus.pred_taken = token[1] & ~busy;
endmodule

// File: doc/bht_table.md
BHT_TABLE -- requirements
Module: bht_table

Interface
REQ-001 Parameter IDX_W, default 10, index width (1024 entries).
REQ-002 Parameter TGT_W, default 32, stored target width.
REQ-003 Parameter INIT_TOKEN, default 2'b01, counter value written during initialisation (weakly not-taken).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (rst==0 sampled at a clk edge resets the block).
REQ-006 rd_addr  input  IDX_W  fetch lookup index (pc[11:2]).
REQ-007 rd_token  output  2  2-bit saturating counter of the entry addressed one cycle earlier.
REQ-008 rd_target  output  TGT_W  predicted target of that entry.
REQ-009 pred_taken  output  1  rd_token[1] & ~busy.
REQ-010 bht_we  input  1  update strobe from the memory stage.
REQ-011 bht_write_addr  input  IDX_W  update index.
REQ-012 bht_din  input  2+TGT_W  update data {token[1:0], target}.
REQ-013 busy  output  1  table initialising; predictions invalid.

Function
REQ-014 Storage: 2**IDX_W entries of 2+TGT_W bits; {token, target} layout identical to bht_din.
REQ-015 Read latency: rd_addr sampled at edge N; rd_token/rd_target valid from edge N until edge N+1.
REQ-016 Write: when bht_we=1 and busy=0 at edge N, entry bht_write_addr holds bht_din after edge N.
REQ-017 Read-during-write same index, same edge: read outputs bht_din (write-first bypass).
REQ-018 Read-during-write different index: read returns old content of rd_addr; write unaffected.
REQ-019 FSM states: INIT, READY; reset enters INIT with init_idx=0.
REQ-020 INIT: each cycle writes {INIT_TOKEN, TGT_W'b0} to init_idx, init_idx increments by 1.
REQ-021 INIT->READY when init_idx == 2**IDX_W-1 has been written; INIT lasts exactly 2**IDX_W cycles.
REQ-022 READY is absorbing until the next reset.
REQ-023 busy=1 in INIT, 0 in READY; bht_we ignored (dropped, not queued) while busy=1.
REQ-024 While busy=1: rd_token=2'b00, rd_target=0, pred_taken=0 regardless of table content.
REQ-025 init_idx is IDX_W+1 bits wide; no wrap-around into index 0 during INIT.
REQ-026 The table itself performs no counter arithmetic; saturating update is computed upstream and bht_din written verbatim.

Reset
REQ-027 rst=0 at any edge: state<=INIT, init_idx<=0, busy<=1, read output registers<=0, regardless of current state (mid-INIT reset restarts from index 0).
REQ-028 Table RAM contents are not reset directly; only the INIT sweep defines them.
REQ-029 First READY cycle is edge 2**IDX_W after the edge where rst is first sampled 1.

Structure
REQ-030 Shared macros file holds BHT_IDX_W, BHT_TGT_W, and token encodings (STRONG_NT 00, WEAK_NT 01, WEAK_T 10, STRONG_T 11).
REQ-031 One sub-module bht_ram: simple dual-port synchronous RAM (1 write port, 1 registered read port), inferable as block RAM; bypass and INIT write muxing live in bht_table.
REQ-032 RAM write port is driven by the INIT sweep in INIT and by the bht_* inputs in READY.

Verification
REQ-033 Release rst, count cycles -> busy=1 for exactly 1024 cycles, then 0; any read afterward returns token 01, target 0.
REQ-034 READY, write addr 0x05 din {2'b11,32'h0000_1040}, next cycle rd_addr 0x05 -> rd_token 11, rd_target 0x1040, pred_taken 1.
REQ-035 READY, same edge write addr 0x3FF din {10,0x2000} and rd_addr 0x3FF -> next cycle rd_token 10, rd_target 0x2000 (bypass).
REQ-036 bht_we=1 to addr 0x10 at INIT cycle 5 -> after READY, addr 0x10 reads token 01, target 0 (write dropped).
REQ-037 rst=0 at INIT cycle 600 held 1 cycle -> busy stays 1 for 1024 further cycles; no early READY.
REQ-038 Back-to-back writes addr 0x20 {01,0x100} then {11,0x200} -> read returns {11,0x200}; neighbour 0x21 unchanged at {01,0}.
